// File: rtl/axi_protocol_checker.sv
// axi_protocol_checker: passive, synthesizable AXI protocol checker for one link.
// Snoops all five channels (inputs only, never drives the bus), tracks outstanding bursts
// and their lengths, and reports violations as sticky flags, a one-cycle pulse and a
// first-error capture (index + cycle count).
//
// Ports:
//   aclk, areset          clock; synchronous active-low reset
//   aw*/w*/b*/ar*/r*_i    snooped AXI channel signals
//   clr_i                 clears err_o, first-error capture and the cycle counter
//   err_o[10:0]           sticky flags: 0-4 stability AW/W/AR/R/B, 5 R without AR,
//                         6 B without completed write, 7 rlast, 8 wlast/W before AW,
//                         9 queue overflow, 10 handshake timeout
//   err_pulse_o           high for one cycle whenever any check fires
//   first_err_idx_o       lowest bit of the first error since reset/clear; 4'hF = none
//   first_err_cyc_o       cycle counter value at that error
//   rd/wr_outstanding_o   occupancy of the AR / AW length queues
//
// Optional feature: define AXI_CHK_TIMEOUT_EN to build the per-channel watchdogs (bit 10).
module axi_protocol_checker #(
  parameter int unsigned DATA_WIDTH      = 16,
  parameter int unsigned ADD_WIDTH       = 8,
  parameter int unsigned ID_WIDTH        = 8,
  parameter int unsigned MAX_OUTSTANDING = 8,
  parameter int unsigned TIMEOUT_CYCLES  = 256
) (
  input  logic                               aclk,
  input  logic                               areset,
  input  logic                               awvalid_i,
  input  logic                               awready_i,
  input  logic [ADD_WIDTH-1:0]               awaddr_i,
  input  logic [7:0]                         awlen_i,
  input  logic [2:0]                         awsize_i,
  input  logic [ID_WIDTH-1:0]                awid_i,
  input  logic                               wvalid_i,
  input  logic                               wready_i,
  input  logic [DATA_WIDTH-1:0]              wdata_i,
  input  logic [DATA_WIDTH/8-1:0]            wstrb_i,
  input  logic                               wlast_i,
  input  logic [ID_WIDTH-1:0]                wid_i,
  input  logic                               bvalid_i,
  input  logic                               bready_i,
  input  logic [ID_WIDTH-1:0]                bid_i,
  input  logic                               arvalid_i,
  input  logic                               arready_i,
  input  logic [ADD_WIDTH-1:0]               araddr_i,
  input  logic [7:0]                         arlen_i,
  input  logic [2:0]                         arsize_i,
  input  logic [ID_WIDTH-1:0]                arid_i,
  input  logic                               rvalid_i,
  input  logic                               rready_i,
  input  logic [DATA_WIDTH-1:0]              rdata_i,
  input  logic [ID_WIDTH-1:0]                rid_i,
  input  logic                               rlast_i,
  input  logic                               clr_i,
  output logic [10:0]                        err_o,
  output logic                               err_pulse_o,
  output logic [3:0]                         first_err_idx_o,
  output logic [31:0]                        first_err_cyc_o,
  output logic [$clog2(MAX_OUTSTANDING):0]   rd_outstanding_o,
  output logic [$clog2(MAX_OUTSTANDING):0]   wr_outstanding_o
);

  localparam int unsigned PtrW = $clog2(MAX_OUTSTANDING);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned AxW  = ADD_WIDTH + 8 + 3 + ID_WIDTH;
  localparam int unsigned WW   = DATA_WIDTH + DATA_WIDTH / 8 + 1 + ID_WIDTH;
  localparam int unsigned RW   = DATA_WIDTH + ID_WIDTH + 1;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  assign aw_hs = awvalid_i & awready_i;
  assign w_hs  = wvalid_i & wready_i;
  assign b_hs  = bvalid_i & bready_i;
  assign ar_hs = arvalid_i & arready_i;
  assign r_hs  = rvalid_i & rready_i;

  // ---------------- Stability: bit order AW, W, AR, R, B ----------------
  logic [4:0]     vld, rdy, pend_q, pend_d, pl_diff, stab_err;
  logic [AxW-1:0] aw_pl, ar_pl, aw_pl_q, ar_pl_q;
  logic [WW-1:0]  w_pl, w_pl_q;
  logic [RW-1:0]  r_pl, r_pl_q;
  logic [ID_WIDTH-1:0] b_pl_q;

  assign vld   = {bvalid_i, rvalid_i, arvalid_i, wvalid_i, awvalid_i};
  assign rdy   = {bready_i, rready_i, arready_i, wready_i, awready_i};
  assign aw_pl = {awaddr_i, awlen_i, awsize_i, awid_i};
  assign ar_pl = {araddr_i, arlen_i, arsize_i, arid_i};
  assign w_pl  = {wdata_i, wstrb_i, wlast_i, wid_i};
  assign r_pl  = {rdata_i, rid_i, rlast_i};
  assign pend_d  = vld & ~rdy;
  assign pl_diff = {bid_i != b_pl_q, r_pl != r_pl_q, ar_pl != ar_pl_q, w_pl != w_pl_q,
                    aw_pl != aw_pl_q};
  // pend_q is cleared by reset, so the first cycle after release never checks stability.
  assign stab_err = pend_q & (~vld | pl_diff);

  // ---------------- Length queues ----------------
  logic [7:0]      ar_mem_q [MAX_OUTSTANDING];
  logic [7:0]      aw_mem_q [MAX_OUTSTANDING];
  logic [PtrW-1:0] ar_wp_q, ar_rp_q, aw_wp_q, aw_rp_q;
  logic [CntW-1:0] ar_cnt_q, ar_cnt_d, aw_cnt_q, aw_cnt_d;
  logic            ar_empty, ar_full, ar_push, ar_pop, ar_ovf;
  logic            aw_empty, aw_full, aw_push, aw_pop, aw_ovf;
  logic [8:0]      rbeat_q, rbeat_d, wbeat_q, wbeat_d;
  logic [15:0]     b_owed_q, b_owed_d;
  logic            r_len_err, w_len_err, r_noar, b_nowr, to_err;

  assign ar_empty = (ar_cnt_q == '0);
  assign aw_empty = (aw_cnt_q == '0);
  assign ar_full  = (ar_cnt_q == CntW'(MAX_OUTSTANDING));
  assign aw_full  = (aw_cnt_q == CntW'(MAX_OUTSTANDING));
  assign ar_pop   = r_hs & rlast_i & ~ar_empty;
  assign aw_pop   = w_hs & wlast_i & ~aw_empty;
  // A pop at the same edge frees the slot, so a push into a full queue is then legal.
  assign ar_push  = ar_hs & (~ar_full | ar_pop);
  assign aw_push  = aw_hs & (~aw_full | aw_pop);
  assign ar_ovf   = ar_hs & ar_full & ~ar_pop;
  assign aw_ovf   = aw_hs & aw_full & ~aw_pop;

  assign r_noar    = rvalid_i & ar_empty;
  assign b_nowr    = bvalid_i & (b_owed_q == '0);
  assign r_len_err = r_hs & ~ar_empty & (rlast_i != (rbeat_q == {1'b0, ar_mem_q[ar_rp_q]}));
  assign w_len_err = w_hs & (aw_empty | (wlast_i != (wbeat_q == {1'b0, aw_mem_q[aw_rp_q]})));

  always_comb begin
    ar_cnt_d = ar_cnt_q;
    if (ar_push && !ar_pop)      ar_cnt_d = ar_cnt_q + CntW'(1);
    else if (!ar_push && ar_pop) ar_cnt_d = ar_cnt_q - CntW'(1);
    aw_cnt_d = aw_cnt_q;
    if (aw_push && !aw_pop)      aw_cnt_d = aw_cnt_q + CntW'(1);
    else if (!aw_push && aw_pop) aw_cnt_d = aw_cnt_q - CntW'(1);
    // Beats are counted only against a tracked burst; any last beat restarts the count.
    rbeat_d = rbeat_q;
    if (r_hs && rlast_i)        rbeat_d = '0;
    else if (r_hs && !ar_empty) rbeat_d = rbeat_q + 9'd1;
    wbeat_d = wbeat_q;
    if (w_hs && wlast_i)        wbeat_d = '0;
    else if (w_hs && !aw_empty) wbeat_d = wbeat_q + 9'd1;
    b_owed_d = b_owed_q + 16'(w_hs & wlast_i) - 16'(b_hs & (b_owed_q != '0));
  end

  always_ff @(posedge aclk) begin
    if (ar_push) ar_mem_q[ar_wp_q] <= arlen_i;
    if (aw_push) aw_mem_q[aw_wp_q] <= awlen_i;
  end

  // ---------------- Watchdog ----------------
`ifdef AXI_CHK_TIMEOUT_EN
  localparam int unsigned ToW = $clog2(TIMEOUT_CYCLES + 1);
  logic [ToW-1:0] to_cnt_q [5];
  logic [ToW-1:0] to_cnt_d [5];

  always_comb begin
    to_err = 1'b0;
    for (int i = 0; i < 5; i++) begin
      to_cnt_d[i] = '0;
      if (pend_d[i]) begin
        // Saturate so a channel stuck forever fires only once.
        to_cnt_d[i] = (to_cnt_q[i] == ToW'(TIMEOUT_CYCLES)) ? to_cnt_q[i] : to_cnt_q[i] + ToW'(1);
        if (to_cnt_q[i] == ToW'(TIMEOUT_CYCLES - 1)) to_err = 1'b1;
      end
    end
  end

  always_ff @(posedge aclk) begin
    for (int i = 0; i < 5; i++) begin
      if (!areset) to_cnt_q[i] <= '0;
      else         to_cnt_q[i] <= to_cnt_d[i];
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES == 0);
  assign to_err = 1'b0;
`endif

  // ---------------- Error capture ----------------
  logic [10:0] fire, err_q, err_d;
  logic        pulse_q;
  logic [3:0]  idx_q, idx_d;
  logic [31:0] fcyc_q, fcyc_d, cyc_q, cyc_d;

  assign fire = {to_err, ar_ovf | aw_ovf, w_len_err, r_len_err, b_nowr, r_noar, stab_err};

  always_comb begin
    // Clear applies to the old state first; a same-edge error is then recorded on top.
    err_d  = (clr_i ? '0 : err_q) | fire;
    idx_d  = clr_i ? 4'hF : idx_q;
    fcyc_d = clr_i ? '0 : fcyc_q;
    cyc_d  = clr_i ? '0 : cyc_q + 32'd1;
    if (idx_d == 4'hF && |fire) begin
      for (int i = 10; i >= 0; i--) begin
        if (fire[i]) idx_d = 4'(i);
      end
      fcyc_d = clr_i ? '0 : cyc_q;
    end
  end

  always_ff @(posedge aclk) begin
    if (!areset) begin
      pend_q   <= '0;
      aw_pl_q  <= '0;
      ar_pl_q  <= '0;
      w_pl_q   <= '0;
      r_pl_q   <= '0;
      b_pl_q   <= '0;
      ar_wp_q  <= '0;
      ar_rp_q  <= '0;
      ar_cnt_q <= '0;
      aw_wp_q  <= '0;
      aw_rp_q  <= '0;
      aw_cnt_q <= '0;
      rbeat_q  <= '0;
      wbeat_q  <= '0;
      b_owed_q <= '0;
      err_q    <= '0;
      pulse_q  <= 1'b0;
      idx_q    <= 4'hF;
      fcyc_q   <= '0;
      cyc_q    <= '0;
    end else begin
      pend_q   <= pend_d;
      aw_pl_q  <= aw_pl;
      ar_pl_q  <= ar_pl;
      w_pl_q   <= w_pl;
      r_pl_q   <= r_pl;
      b_pl_q   <= bid_i;
      if (ar_push) ar_wp_q <= ar_wp_q + PtrW'(1);
      if (ar_pop)  ar_rp_q <= ar_rp_q + PtrW'(1);
      if (aw_push) aw_wp_q <= aw_wp_q + PtrW'(1);
      if (aw_pop)  aw_rp_q <= aw_rp_q + PtrW'(1);
      ar_cnt_q <= ar_cnt_d;
      aw_cnt_q <= aw_cnt_d;
      rbeat_q  <= rbeat_d;
      wbeat_q  <= wbeat_d;
      b_owed_q <= b_owed_d;
      err_q    <= err_d;
      pulse_q  <= |fire;
      idx_q    <= idx_d;
      fcyc_q   <= fcyc_d;
      cyc_q    <= cyc_d;
    end
  end

  assign err_o            = err_q;
  assign err_pulse_o      = pulse_q;
  assign first_err_idx_o  = idx_q;
  assign first_err_cyc_o  = fcyc_q;
  assign rd_outstanding_o = ar_cnt_q;
  assign wr_outstanding_o = aw_cnt_q;

endmodule

// File: tb/tb_axi_protocol_checker.sv
// Self-checking bench for axi_protocol_checker: expectations are queued as stimulus is
// applied and popped/compared once the clock edge that should produce them has passed.
module tb_axi_protocol_checker;

  localparam int unsigned MaxOut = 8;
`ifdef AXI_CHK_TIMEOUT_EN
  localparam logic [10:0] ToBit = 11'h400;
`else
  localparam logic [10:0] ToBit = 11'h000;
`endif

  localparam int SelErr = 0, SelPulse = 1, SelIdx = 2, SelCyc = 3, SelRd = 4, SelWr = 5;

  logic aclk, areset, clr_i;
  logic awvalid, awready, wvalid, wready, wlast, bvalid, bready, arvalid, arready;
  logic rvalid, rready, rlast;
  logic [7:0]  awaddr, araddr, awlen, arlen, awid, wid, bid, arid, rid;
  logic [2:0]  awsize, arsize;
  logic [15:0] wdata, rdata;
  logic [1:0]  wstrb;
  logic [10:0] err;
  logic        err_pulse;
  logic [3:0]  first_idx;
  logic [31:0] first_cyc;
  logic [3:0]  rd_out, wr_out;

  axi_protocol_checker dut (
    .aclk(aclk), .areset(areset),
    .awvalid_i(awvalid), .awready_i(awready), .awaddr_i(awaddr), .awlen_i(awlen),
    .awsize_i(awsize), .awid_i(awid),
    .wvalid_i(wvalid), .wready_i(wready), .wdata_i(wdata), .wstrb_i(wstrb),
    .wlast_i(wlast), .wid_i(wid),
    .bvalid_i(bvalid), .bready_i(bready), .bid_i(bid),
    .arvalid_i(arvalid), .arready_i(arready), .araddr_i(araddr), .arlen_i(arlen),
    .arsize_i(arsize), .arid_i(arid),
    .rvalid_i(rvalid), .rready_i(rready), .rdata_i(rdata), .rid_i(rid), .rlast_i(rlast),
    .clr_i(clr_i),
    .err_o(err), .err_pulse_o(err_pulse), .first_err_idx_o(first_idx),
    .first_err_cyc_o(first_cyc), .rd_outstanding_o(rd_out), .wr_outstanding_o(wr_out)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } sb_t;

  sb_t sb_q[$];
  int  n_checks, n_errors;
  int  cyc_model;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      SelErr:   return {21'd0, err};
      SelPulse: return {31'd0, err_pulse};
      SelIdx:   return {28'd0, first_idx};
      SelCyc:   return first_cyc;
      SelRd:    return {28'd0, rd_out};
      default:  return {28'd0, wr_out};
    endcase
  endfunction

  task automatic expect_val(input string tag, input int sel, input logic [31:0] exp);
    sb_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic expect_state(input string tag, input logic [10:0] e_err, input logic e_pulse,
                              input int e_rd, input int e_wr);
    expect_val({tag, ".err"}, SelErr, {21'd0, e_err});
    expect_val({tag, ".pulse"}, SelPulse, {31'd0, e_pulse});
    expect_val({tag, ".rd"}, SelRd, e_rd);
    expect_val({tag, ".wr"}, SelWr, e_wr);
  endtask

  // Advance one edge, then compare everything queued for it.
  task automatic step();
    sb_t e;
    @(posedge aclk);
    #1;
    if (!areset || clr_i) cyc_model = 0;
    else                  cyc_model++;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_val(e.tag, observe(e.sel), e.exp);
    end
  endtask

  task automatic idle();
    clr_i = 0;
    awvalid = 0; awready = 0; awaddr = 0; awlen = 0; awsize = 3'd1; awid = 0;
    wvalid = 0; wready = 0; wdata = 0; wstrb = 2'b11; wlast = 0; wid = 0;
    bvalid = 0; bready = 0; bid = 0;
    arvalid = 0; arready = 0; araddr = 0; arlen = 0; arsize = 3'd1; arid = 0;
    rvalid = 0; rready = 0; rdata = 0; rid = 0; rlast = 0;
  endtask

  task automatic rand_inputs();
    awvalid = 1'($urandom); awready = 1'($urandom); awaddr = 8'($urandom);
    awlen = 8'($urandom); wvalid = 1'($urandom); wready = 1'($urandom);
    wdata = 16'($urandom); wlast = 1'($urandom); bvalid = 1'($urandom);
    bready = 1'($urandom); arvalid = 1'($urandom); arready = 1'($urandom);
    arlen = 8'($urandom); rvalid = 1'($urandom); rready = 1'($urandom);
    rlast = 1'($urandom); clr_i = 1'($urandom);
  endtask

  task automatic do_clear();
    idle();
    clr_i = 1;
    expect_state("clr", 11'h0, 1'b0, 0, 0);
    expect_val("clr.idx", SelIdx, 32'hF);
    expect_val("clr.cyc", SelCyc, 32'h0);
    step();
    clr_i = 0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    cyc_model = 0;
    idle();
    areset = 0;

    // Reset with random activity on every input.
    for (int i = 0; i < 3; i++) begin
      rand_inputs();
      expect_state("rst", 11'h0, 1'b0, 0, 0);
      expect_val("rst.idx", SelIdx, 32'hF);
      expect_val("rst.cyc", SelCyc, 32'h0);
      step();
    end
    idle();
    areset = 1;
    expect_state("release", 11'h0, 1'b0, 0, 0);
    step();

    // Clean read burst of 4 beats, write burst of 2 beats, one response.
    arvalid = 1; arready = 1; arlen = 8'd3; araddr = 8'h40; arid = 8'd1;
    expect_state("ar", 11'h0, 1'b0, 1, 0);
    step();
    idle();
    for (int b = 0; b < 4; b++) begin
      rvalid = 1; rready = 1; rid = 8'd1; rdata = 16'(b); rlast = (b == 3);
      expect_state("rbeat", 11'h0, 1'b0, (b == 3) ? 0 : 1, 0);
      step();
    end
    idle();
    awvalid = 1; awready = 1; awlen = 8'd1; awaddr = 8'h80;
    expect_state("aw", 11'h0, 1'b0, 0, 1);
    step();
    idle();
    for (int b = 0; b < 2; b++) begin
      wvalid = 1; wready = 1; wdata = 16'(b + 5); wlast = (b == 1);
      expect_state("wbeat", 11'h0, 1'b0, 0, (b == 1) ? 0 : 1);
      step();
    end
    idle();
    bvalid = 1; bready = 1;
    expect_state("b", 11'h0, 1'b0, 0, 0);
    step();

    // AW address changes while stalled.
    idle();
    awvalid = 1; awready = 0; awaddr = 8'h10;
    expect_state("aw_stall", 11'h0, 1'b0, 0, 0);
    step();
    awaddr = 8'h14;
    expect_state("aw_unstable", 11'h001, 1'b1, 0, 0);
    expect_val("aw_unstable.idx", SelIdx, 32'h0);
    expect_val("aw_unstable.cyc", SelCyc, cyc_model);
    step();
    awready = 1;
    expect_state("aw_accept", 11'h001, 1'b0, 0, 1);
    step();
    idle();
    wvalid = 1; wready = 1; wlast = 1;
    expect_state("w_single", 11'h001, 1'b0, 0, 0);
    step();
    idle();
    bvalid = 1; bready = 1;
    expect_state("b_single", 11'h001, 1'b0, 0, 0);
    step();
    do_clear();

    // R with no outstanding AR.
    rvalid = 1; rready = 1; rlast = 1;
    expect_state("r_noar", 11'h020, 1'b1, 0, 0);
    expect_val("r_noar.idx", SelIdx, 32'h5);
    step();
    idle();
    expect_state("r_noar_after", 11'h020, 1'b0, 0, 0);
    step();
    do_clear();

    // rlast on the first beat of a 2-beat burst.
    arvalid = 1; arready = 1; arlen = 8'd1;
    expect_state("ar_len1", 11'h0, 1'b0, 1, 0);
    step();
    idle();
    rvalid = 1; rready = 1; rlast = 1;
    expect_state("rlast_early", 11'h080, 1'b1, 0, 0);
    expect_val("rlast_early.idx", SelIdx, 32'h7);
    step();
    do_clear();

    // B with nothing owed, then W with empty AW queue.
    bvalid = 1; bready = 1;
    expect_state("b_noowe", 11'h040, 1'b1, 0, 0);
    expect_val("b_noowe.idx", SelIdx, 32'h6);
    step();
    do_clear();
    wvalid = 1; wready = 1; wlast = 1;
    expect_state("w_noaw", 11'h100, 1'b1, 0, 0);
    expect_val("w_noaw.idx", SelIdx, 32'h8);
    step();
    idle();
    bvalid = 1; bready = 1;
    expect_state("b_after_w", 11'h100, 1'b0, 0, 0);
    step();
    do_clear();

    // Fill the AR queue, push+pop while full, then overflow.
    arvalid = 1; arready = 1; arlen = 8'd0;
    for (int k = 1; k <= int'(MaxOut); k++) begin
      expect_state("fill", 11'h0, 1'b0, k, 0);
      step();
    end
    rvalid = 1; rready = 1; rlast = 1;
    expect_state("full_pushpop", 11'h0, 1'b0, MaxOut, 0);
    step();
    rvalid = 0; rready = 0; rlast = 0;
    expect_state("overflow", 11'h200, 1'b1, MaxOut, 0);
    expect_val("overflow.idx", SelIdx, 32'h9);
    step();
    idle();
    for (int k = int'(MaxOut) - 1; k >= 0; k--) begin
      rvalid = 1; rready = 1; rlast = 1;
      expect_state("drain", 11'h200, 1'b0, k, 0);
      step();
    end
    do_clear();

    // Reset in the middle of a read burst discards it silently.
    arvalid = 1; arready = 1; arlen = 8'd3;
    expect_state("mid_ar", 11'h0, 1'b0, 1, 0);
    step();
    idle();
    rvalid = 1; rready = 1;
    expect_state("mid_r", 11'h0, 1'b0, 1, 0);
    step();
    idle();
    areset = 0;
    expect_state("mid_rst", 11'h0, 1'b0, 0, 0);
    expect_val("mid_rst.idx", SelIdx, 32'hF);
    step();
    areset = 1;
    arvalid = 1; arready = 1; arlen = 8'd0;
    expect_state("post_rst_ar", 11'h0, 1'b0, 1, 0);
    step();
    idle();
    rvalid = 1; rready = 1; rlast = 1;
    expect_state("post_rst_r", 11'h0, 1'b0, 0, 0);
    step();
    idle();

    // AR held valid without ready for the watchdog limit.
    arvalid = 1; arready = 0; arlen = 8'd0; araddr = 8'h22;
    for (int i = 1; i <= 256; i++) begin
      if (i == 255 || i == 256) begin
        expect_val("timeout.err", SelErr, (i == 256) ? {21'd0, ToBit} : 32'h0);
        expect_val("timeout.pulse", SelPulse, (i == 256) ? {31'd0, |ToBit} : 32'h0);
      end
      step();
    end
    arready = 1;
    expect_state("timeout_accept", ToBit, 1'b0, 1, 0);
    step();
    idle();
    rvalid = 1; rready = 1; rlast = 1;
    expect_state("timeout_r", ToBit, 1'b0, 0, 0);
    expect_val("timeout.idx", SelIdx, (ToBit != 0) ? 32'hA : 32'hF);
    step();
    idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
